// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment multiplexed BCD counter:
// BCD digit type, segment code table and the bidir output-enable constant.
package seg7_pkg;

    typedef logic [3:0] bcd_t;

    // Low five bidir pins are outputs: four digit enables plus wrap pulse.
    localparam logic [7:0] UIO_OE = 8'h1F;

    // Segments a..g active-high, bit 0 = a.
    function automatic logic [6:0] seg7_encode(input bcd_t d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/tt_um_seg7_mux_counter_if.sv
// Pin bundle of the counter: enable, dedicated inputs/outputs and the
// bidirectional pins. master drives the inputs, slave is the design side.
interface tt_um_seg7_mux_counter_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
    modport slave  (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/bcd_digit.sv
// One BCD digit of the counter chain. Steps up or down when step is high,
// reporting carry/borrow to the next digit. clear beats load beats step;
// carry_out is suppressed while clear or load so no wrap is reported then.
module bcd_digit
    import seg7_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clear,
    input  logic load,
    input  bcd_t load_val,
    input  logic step,
    input  logic down,
    output bcd_t digit,
    output logic carry_out
);

    assign carry_out = step && !clear && !load &&
                       (down ? (digit == 4'd0) : (digit == 4'd9));

    // Digit register: clear > load > step, frozen when en is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            digit <= '0;
        end else if (en) begin
            if (clear)
                digit <= '0;
            else if (load)
                digit <= load_val;
            else if (step) begin
                if (down)
                    digit <= (digit == 4'd0) ? 4'd9 : digit - 4'd1;
                else
                    digit <= (digit == 4'd9) ? 4'd0 : digit + 4'd1;
            end
        end
    end

endmodule

// File: rtl/tt_um_seg7_mux_counter.sv
// Multiplexed seven-segment BCD up/down counter.
// A prescaler produces a count tick every TICK_CYCLES clocks while run is
// high; a chain of bcd_digit instances counts with carry/borrow; a scan
// counter walks the digit index every SCAN_CYCLES clocks and the selected
// digit is encoded and registered onto the pins.
// Optional: define SEG7_DP_BLINK_EN to blink the decimal point of digit 0
// during the second half of each prescaler period.
module tt_um_seg7_mux_counter
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int TICK_CYCLES = 10000000,
    parameter int SCAN_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int PW = $clog2(TICK_CYCLES);
    localparam int SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_CYCLES - 1);
    localparam logic [1:0]    IDX_LAST   = 2'(NUM_DIGITS - 1);

    logic run, down, clear, load;
    bcd_t load_val;

    assign run      = ui_in[0];
    assign down     = ui_in[1];
    assign clear    = ui_in[2];
    assign load     = ui_in[3];
    assign load_val = (ui_in[7:4] > 4'd9) ? 4'd9 : ui_in[7:4];

    logic [PW-1:0] presc;
    logic          tick;

    assign tick = ena && run && (presc == PRESC_LAST);

    // Prescaler: free-runs while run, holds otherwise; clear restarts it.
    always_ff @(posedge clk) begin
        if (!rst_n)
            presc <= '0;
        else if (ena) begin
            if (clear)
                presc <= '0;
            else if (run)
                presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
        end
    end

    bcd_t [NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS:0]   step_chain;
    logic                  wrap;

    assign step_chain[0] = tick;
    assign wrap          = step_chain[NUM_DIGITS];

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (ena),
            .clear     (clear),
            .load      (load),
            .load_val  ((g == 0) ? load_val : bcd_t'(0)),
            .step      (step_chain[g]),
            .down      (down),
            .digit     (digits[g]),
            .carry_out (step_chain[g+1])
        );
    end

    logic [SW-1:0] scan_cnt;
    logic [1:0]    idx;

    // Scan timer: advances the displayed digit index regardless of run.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (ena) begin
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt <= '0;
                idx      <= (idx == IDX_LAST) ? 2'd0 : idx + 2'd1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
        end
    end

    bcd_t cur_digit;

    // Mux the digit currently selected by the scan index.
    always_comb begin
        cur_digit = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (idx == 2'(i))
                cur_digit = digits[i];
    end

    logic dp;
`ifdef SEG7_DP_BLINK_EN
    localparam logic [PW-1:0] PRESC_HALF = PW'(TICK_CYCLES / 2);
    assign dp = (idx == 2'd0) && (presc >= PRESC_HALF);
`else
    assign dp = 1'b0;
`endif

    logic [3:0] dig_en_q;
    logic       wrap_q;

    // Pin registers: one cycle behind index/digit; wrap pulse drops when disabled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            uo_out   <= '0;
            dig_en_q <= '0;
            wrap_q   <= 1'b0;
        end else if (ena) begin
            uo_out   <= {dp, seg7_encode(cur_digit)};
            dig_en_q <= 4'b0001 << idx;
            wrap_q   <= wrap;
        end else begin
            wrap_q   <= 1'b0;
        end
    end

    assign uio_out = {3'b000, wrap_q, dig_en_q};
    assign uio_oe  = UIO_OE;

    logic unused_ok;
    assign unused_ok = &{1'b0, uio_in};

endmodule

// File: tb/tb_tt_um_seg7_mux_counter.sv
// Self-checking bench for tt_um_seg7_mux_counter (2 digits, tick 4, scan 2).
// Reference model keeps the count as a plain integer 0..99.
module tb_tt_um_seg7_mux_counter;

    localparam int N = 2;
    localparam int T = 4;
    localparam int S = 2;
    localparam int MAXC = 99;

    logic clk;
    logic rst_n;
    tt_um_seg7_mux_counter_if io ();

    tt_um_seg7_mux_counter #(.NUM_DIGITS(N), .TICK_CYCLES(T), .SCAN_CYCLES(S)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (io.ena),
        .ui_in   (io.ui_in),
        .uo_out  (io.uo_out),
        .uio_in  (io.uio_in),
        .uio_out (io.uio_out),
        .uio_oe  (io.uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    int m_count = 0, m_presc = 0, m_scan = 0, m_idx = 0;
    logic [7:0] m_uo = '0, m_uio = '0;

    task automatic model_update();
        logic run, down, clr, ld, tick, wrap, dp;
        int v, d;
        if (!rst_n) begin
            m_count = 0; m_presc = 0; m_scan = 0; m_idx = 0;
            m_uo = '0; m_uio = '0;
        end else if (io.ena) begin
            run  = io.ui_in[0];
            down = io.ui_in[1];
            clr  = io.ui_in[2];
            ld   = io.ui_in[3];
            v    = int'(io.ui_in[7:4]);
            d    = (m_idx == 0) ? m_count % 10 : (m_count / 10) % 10;
`ifdef SEG7_DP_BLINK_EN
            dp = (m_idx == 0) && (m_presc >= T / 2);
`else
            dp = 1'b0;
`endif
            m_uo  = {dp, seg_tab[d]};
            tick  = run && (m_presc == T - 1);
            wrap  = tick && !clr && !ld && (down ? (m_count == 0) : (m_count == MAXC));
            m_uio = 8'(1 << m_idx) | (wrap ? 8'h10 : 8'h00);
            if (run) m_presc = (m_presc + 1) % T;
            if (clr) begin
                m_count = 0; m_presc = 0;
            end else if (ld)
                m_count = (v > 9) ? 9 : v;
            else if (tick)
                m_count = down ? (m_count + MAXC) % (MAXC + 1) : (m_count + 1) % (MAXC + 1);
            m_scan = m_scan + 1;
            if (m_scan == S) begin
                m_scan = 0;
                m_idx  = (m_idx + 1) % N;
            end
        end else begin
            m_uio[4] = 1'b0;
        end
    endtask

    // One clock: DUT and model advance on the rising edge, outputs sampled at the falling edge.
    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        io.ui_in = 8'($urandom);
        io.uio_in = 8'($urandom);
        step(); step();
        checks++;
        if ({io.uo_out, io.uio_out[4:0]} !== 13'h0) begin
            errors++;
            $display("FAIL reset_state: got uo=%h uio=%h expected uo=00 uio=00", io.uo_out, io.uio_out);
        end
        checks++;
        if (io.uio_oe !== 8'h1F) begin
            errors++;
            $display("FAIL uio_oe: got %h expected 1f", io.uio_oe);
        end
        io.ui_in = 8'h00;
        rst_n = 1'b1;
        step();
        checks++;
        if ({io.uo_out, io.uio_out} !== 16'h3F01) begin
            errors++;
            $display("FAIL first_after_reset: got uo=%h uio=%h expected uo=3f uio=01", io.uo_out, io.uio_out);
        end
    endtask

    task automatic test_count_up();
        io.ui_in = 8'h01;
        for (int i = 0; i < 40; i++) begin
            step();
            checks++;
            if ({io.uo_out, io.uio_out} !== {m_uo, m_uio}) begin
                errors++;
                $display("FAIL count_up c%0d: got uo=%h uio=%h expected uo=%h uio=%h", i, io.uo_out, io.uio_out, m_uo, m_uio);
            end
        end
        io.ui_in = 8'h00;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (io.uio_out[3:0] == 4'h1 && io.uo_out[6:0] !== 7'h3F) begin
                errors++;
                $display("FAIL count_10_digit0: got %h expected 3f", io.uo_out[6:0]);
            end else if (io.uio_out[3:0] == 4'h2 && io.uo_out[6:0] !== 7'h06) begin
                errors++;
                $display("FAIL count_10_digit1: got %h expected 06", io.uo_out[6:0]);
            end else if (io.uio_out[3:0] != 4'h1 && io.uio_out[3:0] != 4'h2) begin
                errors++;
                $display("FAIL count_10_enable: got %h expected 1 or 2", io.uio_out[3:0]);
            end
        end
    endtask

    task automatic test_wrap_up();
        int pulses = 0;
        io.ui_in = 8'h04; step();
        io.ui_in = 8'h98; step();
        io.ui_in = 8'h01;
        for (int i = 0; i < 91 * T + 2; i++) begin
            step();
            pulses += int'(io.uio_out[4]);
            checks++;
            if ({io.uo_out, io.uio_out} !== {m_uo, m_uio}) begin
                errors++;
                $display("FAIL wrap_up c%0d: got uo=%h uio=%h expected uo=%h uio=%h", i, io.uo_out, io.uio_out, m_uo, m_uio);
            end
        end
        io.ui_in = 8'h00;
        step();
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL wrap_up_pulses: got %0d expected 1", pulses);
        end
        checks++;
        if (io.uo_out[6:0] !== 7'h3F) begin
            errors++;
            $display("FAIL wrap_up_zero: got %h expected 3f", io.uo_out[6:0]);
        end
    endtask

    task automatic test_wrap_down();
        int pulses = 0;
        io.ui_in = 8'h04; step();
        io.ui_in = 8'h03;
        for (int i = 0; i < T + 4; i++) begin
            if (i == T) io.ui_in = 8'h00;
            step();
            pulses += int'(io.uio_out[4]);
            checks++;
            if ({io.uo_out, io.uio_out} !== {m_uo, m_uio}) begin
                errors++;
                $display("FAIL wrap_down c%0d: got uo=%h uio=%h expected uo=%h uio=%h", i, io.uo_out, io.uio_out, m_uo, m_uio);
            end
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL wrap_down_pulses: got %0d expected 1", pulses);
        end
        checks++;
        if (io.uo_out[6:0] !== 7'h6F) begin
            errors++;
            $display("FAIL wrap_down_99: got %h expected 6f", io.uo_out[6:0]);
        end
    endtask

    task automatic test_load();
        io.ui_in = 8'hC8; step();
        io.ui_in = 8'h00;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (io.uio_out[3:0] == 4'h1 && io.uo_out[6:0] !== 7'h6F) begin
                errors++;
                $display("FAIL load_saturate: got %h expected 6f", io.uo_out[6:0]);
            end else if (io.uio_out[3:0] == 4'h2 && io.uo_out[6:0] !== 7'h3F) begin
                errors++;
                $display("FAIL load_upper_zero: got %h expected 3f", io.uo_out[6:0]);
            end
        end
        io.ui_in = 8'h5C; step();
        io.ui_in = 8'h00;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (io.uo_out[6:0] !== 7'h3F) begin
                errors++;
                $display("FAIL clear_over_load: got %h expected 3f", io.uo_out[6:0]);
            end
        end
    endtask

    task automatic test_scan_idle();
        int ones = 0;
        io.ui_in = 8'h00;
        for (int i = 0; i < 4; i++) begin
            step();
            if (io.uio_out[3:0] == 4'h1) ones++;
            checks++;
            if ({io.uo_out, io.uio_out} !== {m_uo, m_uio}) begin
                errors++;
                $display("FAIL scan_idle c%0d: got uo=%h uio=%h expected uo=%h uio=%h", i, io.uo_out, io.uio_out, m_uo, m_uio);
            end
        end
        checks++;
        if (ones !== 2) begin
            errors++;
            $display("FAIL scan_duty: got %0d slots on digit0 expected 2", ones);
        end
    endtask

    task automatic test_ena_freeze();
        logic [7:0] uo_s, uio_s;
        io.ui_in = 8'h01;
        for (int i = 0; i < 3; i++) step();
        uo_s = io.uo_out; uio_s = io.uio_out;
        io.ena = 1'b0;
        for (int i = 0; i < 10; i++) begin
            io.ui_in = 8'($urandom);
            step();
            checks++;
            if ({io.uo_out, io.uio_out} !== {uo_s, uio_s & 8'hEF}) begin
                errors++;
                $display("FAIL ena_freeze c%0d: got uo=%h uio=%h expected uo=%h uio=%h", i, io.uo_out, io.uio_out, uo_s, uio_s & 8'hEF);
            end
        end
        io.ena = 1'b1;
        io.ui_in = 8'h00;
        step();
        checks++;
        if ({io.uo_out, io.uio_out} !== {m_uo, m_uio}) begin
            errors++;
            $display("FAIL ena_resume: got uo=%h uio=%h expected uo=%h uio=%h", io.uo_out, io.uio_out, m_uo, m_uio);
        end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        io.ui_in = 8'h04; step();
        io.ui_in = 8'h78; step();
        io.ui_in = 8'h01;
        for (int i = 0; i < 30 * T; i++) step();
        io.ui_in = 8'h00;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (io.uio_out[3:0] == 4'h1 && io.uo_out[6:0] !== 7'h07) begin
                errors++;
                $display("FAIL count37_digit0: got %h expected 07", io.uo_out[6:0]);
            end else if (io.uio_out[3:0] == 4'h2 && io.uo_out[6:0] !== 7'h4F) begin
                errors++;
                $display("FAIL count37_digit1: got %h expected 4f", io.uo_out[6:0]);
            end
        end
        io.ui_in = 8'h01;
        rst_n = 1'b0;
        step();
        checks++;
        if ({io.uo_out, io.uio_out} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_mid: got uo=%h uio=%h expected uo=00 uio=00", io.uo_out, io.uio_out);
        end
        rst_n = 1'b1;
        step();
        pulses += int'(io.uio_out[4]);
        checks++;
        if ({io.uo_out, io.uio_out} !== 16'h3F01) begin
            errors++;
            $display("FAIL reset_mid_release: got uo=%h uio=%h expected uo=3f uio=01", io.uo_out, io.uio_out);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            pulses += int'(io.uio_out[4]);
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL reset_mid_no_wrap: got %0d pulses expected 0", pulses);
        end
    endtask

    task automatic test_random();
        logic [7:0] ui;
        for (int i = 0; i < 400; i++) begin
            ui    = 8'($urandom);
            ui[0] = ($urandom_range(0, 4) != 0);
            ui[2] = ($urandom_range(0, 40) == 0);
            ui[3] = ($urandom_range(0, 25) == 0);
            io.ui_in = ui;
            io.uio_in = 8'($urandom);
            io.ena = ($urandom_range(0, 9) != 0);
            rst_n = ($urandom_range(0, 150) != 0);
            step();
            checks++;
            if ({io.uo_out, io.uio_out} !== {m_uo, m_uio}) begin
                errors++;
                $display("FAIL random c%0d: got uo=%h uio=%h expected uo=%h uio=%h", i, io.uo_out, io.uio_out, m_uo, m_uio);
            end
        end
        io.ena = 1'b1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        io.ena = 1'b1;
        io.ui_in = 8'h00;
        io.uio_in = 8'h00;
        @(negedge clk);
        test_reset();
        test_count_up();
        test_wrap_up();
        test_wrap_down();
        test_load();
        test_scan_idle();
        test_ena_freeze();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tt_um_seg7_mux_counter.md
TT_UM_SEG7_MUX_COUNTER -- requirements
Module: tt_um_seg7_mux_counter

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of BCD digits counted and scanned (legal 1..4).
REQ-002 SHALL have parameter TICK_CYCLES, default 10000000, clk cycles per count step (legal >= 2).
REQ-003 SHALL have parameter SCAN_CYCLES, default 1000, clk cycles per digit scan slot (legal >= 1).
REQ-004 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port ena  in  1  design enable; 0 freezes all state, outputs still driven.
REQ-007 SHALL have port ui_in  in  8  [0] run, [1] down, [2] clear, [3] load, [7:4] load value.
REQ-008 SHALL have port uo_out  out  8  [6:0] segments a..g active-high, [7] decimal point.
REQ-009 SHALL have port uio_in  in  8  unused, ignored.
REQ-010 SHALL have port uio_out  out  8  [3:0] one-hot digit enable, [4] wrap pulse, [7:5] 0.
REQ-011 SHALL have port uio_oe  out  8  constant 8'h1F.

Function
REQ-012 Prescaler SHALL count 0..TICK_CYCLES-1 while run=1 and ena=1, hold while run=0, and produce one-cycle tick at terminal count, then return to 0.
REQ-013 On tick with down=0, digit chain SHALL increment BCD with carry (9->0 carries into next digit).
REQ-014 On tick with down=1, chain SHALL decrement BCD with borrow (0->9 borrows).
REQ-015 Overflow (all 9 up) SHALL give all 0; underflow (all 0 down) SHALL give all 9; either SHALL assert uio_out[4] for exactly one cycle.
REQ-016 clear=1 SHALL zero digits and prescaler next cycle; priority clear > load > tick.
REQ-017 load=1 SHALL set digit 0 to ui_in[7:4] (values >9 saturate to 9) and zero higher digits; prescaler unaffected.
REQ-018 Scan counter SHALL count 0..SCAN_CYCLES-1 whenever ena=1, advancing digit index 0..NUM_DIGITS-1 with wrap at terminal count, independent of run.
REQ-019 uo_out and uio_out SHALL be registered: one cycle latency from index/digit value to pins.
REQ-020 uio_out[3:0] SHALL be one-hot of index; bits >= NUM_DIGITS SHALL be 0.
REQ-021 Segment codes 0..9 SHALL be 3F,06,5B,4F,66,6D,7D,07,7F,6F.
REQ-022 ena=0 SHALL freeze prescaler, digits, scan and wrap pulse (pulse deasserts).

Reset
REQ-023 rst_n=0 at clock edge SHALL zero prescaler, digits, scan counter, index, uo_out, uio_out[4:0]; reset overrides ena and all controls.
REQ-024 First cycle after reset release SHALL drive uo_out 8'h3F, uio_out 8'h01 (when ena=1).
REQ-025 Reset mid-count SHALL discard count; no wrap pulse generated.

Configuration
REQ-026 Macro SEG7_DP_BLINK_EN defined: uo_out[7]=1 while digit 0 enabled and prescaler >= TICK_CYCLES/2; undefined: uo_out[7] SHALL be constant 0.

Structure
REQ-027 Shared package seg7_pkg SHALL hold the segment code table, the BCD digit type, and uio_oe constant.
REQ-028 Sub-module bcd_digit SHALL implement one up/down digit with carry/borrow in/out, clear and load; instantiated NUM_DIGITS times.

Verification (NUM_DIGITS=2, TICK_CYCLES=4, SCAN_CYCLES=2 unless stated)
REQ-029 Reset, run=1 up, 40 cycles -> count 10; digit0 shows 3F, digit1 shows 06.
REQ-030 Load 9 with digit1 driven to 9 by 90 ticks, one more tick -> 00 and uio_out[4]=1 for exactly one cycle.
REQ-031 From 00, down=1, one tick -> 99, wrap pulse one cycle.
REQ-032 load=1, ui_in[7:4]=0xC -> digit0=9; clear=1 and load=1 same cycle -> 00.
REQ-033 ena=1, run=0 -> uio_out[3:0] sequence 01,01,02,02,01 and count unchanged.
REQ-034 rst_n=0 for one cycle at count 37 -> uo_out 00 next cycle, then 3F/01, no wrap pulse.
